// File: rtl/sdr_proto_mon.sv
// Passive SDRAM protocol monitor: tracks per-bank state/timing from the command pins and flags violations.
// Latency: a violation sampled on edge N is visible in err_* / viol_cnt after edge N; observe-only, no backpressure.
module sdr_proto_mon #(
    parameter int NUM_BANKS    = 4,
    parameter int ADDR_W       = 13,
    parameter int BURST_LENGTH = 4,
    parameter int TRCD         = 3,
    parameter int TRP          = 3,
    parameter int TRAS         = 6,
    parameter int TRFC         = 7,
    parameter int CNT_W        = 16
) (
    input  logic                         sdram_clk,
    input  logic                         sdram_resetn,
    input  logic                         sdr_init_done,
    input  logic                         sdr_cs_n,
    input  logic                         sdr_ras_n,
    input  logic                         sdr_cas_n,
    input  logic                         sdr_we_n,
    input  logic [$clog2(NUM_BANKS)-1:0] sdr_ba,
    input  logic [ADDR_W-1:0]            sdr_addr,
    input  logic                         err_clr,
    output logic [NUM_BANKS-1:0]         bank_open,
    output logic [5:0]                   err_flags,
    output logic                         err_valid,
    output logic [$clog2(NUM_BANKS)-1:0] err_bank,
    output logic [CNT_W-1:0]             viol_cnt
);

    localparam int BA_W   = $clog2(NUM_BANKS);
    localparam int MAX_A  = (TRCD > TRP) ? TRCD : TRP;
    localparam int MAX_B  = (TRAS > TRFC) ? TRAS : TRFC;
    localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAXT   = (MAX_C > BURST_LENGTH) ? MAX_C : BURST_LENGTH;
    localparam int CW     = $clog2(MAXT + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAXT);
    localparam logic [CW-1:0] ONE     = CW'(1);
    // Timed states are left one edge early so the command at +T already sees the new state.
    localparam logic [CW-1:0] RCD_END = CW'(TRCD - 1);
    localparam logic [CW-1:0] RP_END  = CW'(TRP - 1);
    localparam logic [CW-1:0] RFC_END = CW'(TRFC - 1);
    localparam logic [CW-1:0] BL_END  = CW'(BURST_LENGTH);
    localparam logic [CW-1:0] RAS_MIN = CW'(TRAS);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ACTIVATING, S_ACTIVE,
        S_BURST, S_BURST_AP, S_PRECHARGING, S_REFRESHING
    } bank_state_t;

    // Enum order matches {ras_n,cas_n,we_n} with cs_n low.
    typedef enum logic [2:0] {
        C_MRS, C_REF, C_PRE, C_ACT, C_WR, C_RD, C_BST, C_NOP
    } cmd_t;

    cmd_t                         cmd;
    bank_state_t                  st_q   [NUM_BANKS];
    bank_state_t                  st_d   [NUM_BANKS];
    logic [CW-1:0]                cnt_q  [NUM_BANKS];
    logic [CW-1:0]                cnt_d  [NUM_BANKS];
    logic [CW-1:0]                ras_q  [NUM_BANKS];
    logic [CW-1:0]                ras_d  [NUM_BANKS];
    logic [NUM_BANKS-1:0][5:0]    viol;
    logic [5:0]                   viol_now;
    logic                         viol_any;
    logic [BA_W-1:0]              viol_bank;
    logic                         all_idle;
    logic                         unused_addr;

    assign cmd         = sdr_cs_n ? C_NOP : cmd_t'({sdr_ras_n, sdr_cas_n, sdr_we_n});
    assign unused_addr = ^sdr_addr;

    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_open[i] = st_q[i] inside {S_ACTIVATING, S_ACTIVE, S_BURST, S_BURST_AP};
            if (st_q[i] != S_IDLE) all_idle = 1'b0;
        end
    end

    always_comb begin
        logic tgt;
        tgt = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            tgt      = (sdr_ba == BA_W'(i));
            st_d[i]  = st_q[i];
            cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + ONE;
            ras_d[i] = (ras_q[i] == CNT_MAX) ? ras_q[i] : ras_q[i] + ONE;
            viol[i]  = '0;

            case (st_q[i])
                S_INIT:        if (sdr_init_done) st_d[i] = S_IDLE;
                S_ACTIVATING:  if (cnt_q[i] >= RCD_END) st_d[i] = S_ACTIVE;
                S_BURST:       if (cnt_q[i] >= BL_END) st_d[i] = S_ACTIVE;
                S_BURST_AP:    if (cnt_q[i] >= BL_END) begin
                                   st_d[i]  = S_PRECHARGING;
                                   cnt_d[i] = ONE;
                               end
                S_PRECHARGING: if (cnt_q[i] >= RP_END) st_d[i] = S_IDLE;
                S_REFRESHING:  if (cnt_q[i] >= RFC_END) st_d[i] = S_IDLE;
                default: ;
            endcase

            if (st_q[i] == S_INIT) begin
                if (cmd == C_BST || (tgt && (cmd inside {C_ACT, C_RD, C_WR})))
                    viol[i][5] = 1'b1;
            end else if (st_q[i] == S_REFRESHING) begin
                if (cmd != C_NOP) viol[i][4] = 1'b1;
            end else begin
                case (cmd)
                    C_ACT: if (tgt) begin
                        // An ACT into PRECHARGING is flagged but still opens the row.
                        if (st_q[i] == S_IDLE || st_q[i] == S_PRECHARGING) begin
                            viol[i][3] = (st_q[i] == S_PRECHARGING);
                            st_d[i]    = S_ACTIVATING;
                            cnt_d[i]   = ONE;
                            ras_d[i]   = ONE;
                        end else begin
                            viol[i][0] = 1'b1;
                        end
                    end
                    C_RD, C_WR: if (tgt) begin
                        if (st_q[i] == S_ACTIVE || st_q[i] == S_BURST) begin
                            st_d[i]  = sdr_addr[10] ? S_BURST_AP : S_BURST;
                            cnt_d[i] = ONE;
                        end else if (st_q[i] == S_ACTIVATING) begin
                            viol[i][1] = 1'b1;
                        end else begin
                            viol[i][0] = 1'b1;
                        end
                    end
                    C_PRE: if ((tgt || sdr_addr[10]) && bank_open[i]) begin
                        viol[i][2] = (ras_q[i] < RAS_MIN);
                        st_d[i]    = S_PRECHARGING;
                        cnt_d[i]   = ONE;
                    end
                    C_REF: begin
                        if (!all_idle) begin
                            viol[i][4] = (st_q[i] != S_IDLE);
                        end else begin
                            st_d[i]  = S_REFRESHING;
                            cnt_d[i] = ONE;
                        end
                    end
                    C_MRS: viol[i][0] = (st_q[i] != S_IDLE);
                    C_BST: if (st_q[i] == S_BURST) st_d[i] = S_ACTIVE;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        viol_now  = '0;
        viol_bank = '0;
        for (int i = 0; i < NUM_BANKS; i++) viol_now = viol_now | viol[i];
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (|viol[i]) viol_bank = BA_W'(i);
        end
        viol_any = |viol_now;
    end

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                st_q[i]  <= S_INIT;
                cnt_q[i] <= '0;
                ras_q[i] <= '0;
            end
            err_flags <= '0;
            err_valid <= 1'b0;
            err_bank  <= '0;
            viol_cnt  <= '0;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                ras_q[i] <= ras_d[i];
            end
            // A clear in the same cycle as a violation keeps only the new violation.
            if (err_clr) begin
                err_flags <= viol_now;
                viol_cnt  <= viol_any ? CNT_W'(1) : '0;
                err_valid <= viol_any;
                err_bank  <= viol_any ? viol_bank : '0;
            end else begin
                err_flags <= err_flags | viol_now;
                if (viol_any && !(&viol_cnt)) viol_cnt <= viol_cnt + CNT_W'(1);
                if (viol_any && !err_valid) begin
                    err_valid <= 1'b1;
                    err_bank  <= viol_bank;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdr_proto_mon.sv
// Scoreboard bench for sdr_proto_mon: driver queues expected outputs, negedge monitor compares.
module tb_sdr_proto_mon;

    localparam int CW = 4;

    localparam logic [3:0] MRS = 4'b0000;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] NOP = 4'b0111;

    localparam int F_FLAGS = 0;
    localparam int F_CNT   = 1;
    localparam int F_VALID = 2;
    localparam int F_BANK  = 3;
    localparam int F_OPEN  = 4;

    logic          clk = 1'b0;
    logic          sdram_resetn;
    logic          sdr_init_done;
    logic          sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [1:0]    sdr_ba;
    logic [12:0]   sdr_addr;
    logic          err_clr;
    logic [3:0]    bank_open;
    logic [5:0]    err_flags;
    logic          err_valid;
    logic [1:0]    err_bank;
    logic [CW-1:0] viol_cnt;

    sdr_proto_mon #(.CNT_W(CW)) dut (
        .sdram_clk     (clk),
        .sdram_resetn  (sdram_resetn),
        .sdr_init_done (sdr_init_done),
        .sdr_cs_n      (sdr_cs_n),
        .sdr_ras_n     (sdr_ras_n),
        .sdr_cas_n     (sdr_cas_n),
        .sdr_we_n      (sdr_we_n),
        .sdr_ba        (sdr_ba),
        .sdr_addr      (sdr_addr),
        .err_clr       (err_clr),
        .bank_open     (bank_open),
        .err_flags     (err_flags),
        .err_valid     (err_valid),
        .err_bank      (err_bank),
        .viol_cnt      (viol_cnt)
    );

    typedef struct {
        string name;
        int    when;
        int    field;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   tests  = 0;
    int   fails  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic int actual(input int f);
        case (f)
            F_FLAGS: return int'(err_flags);
            F_CNT:   return int'(viol_cnt);
            F_VALID: return int'(err_valid);
            F_BANK:  return int'(err_bank);
            default: return int'(bank_open);
        endcase
    endfunction

    // Monitor: pops every expectation due after the latest edge and compares mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        while (sb.size() > 0 && sb[0].when <= edge_n) begin
            e = sb.pop_front();
            tests++;
            a = actual(e.field);
            if (e.when != edge_n) begin
                fails++;
                $display("FAIL %s: check due after edge %0d not sampled (now edge %0d)", e.name, e.when, edge_n);
            end else if (a != e.val) begin
                fails++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", e.name, a, e.val, edge_n);
            end
        end
    end

    task automatic chk(input string n, input int f, input int v);
        exp_t e;
        e.name  = n;
        e.when  = edge_n;
        e.field = f;
        e.val   = v;
        sb.push_back(e);
    endtask

    task automatic step(input logic [3:0] c, input int ba = 0, input bit a10 = 1'b0, input bit clr = 1'b0);
        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = c;
        sdr_ba       = ba[1:0];
        sdr_addr     = '0;
        sdr_addr[10] = a10;
        err_clr      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) step(NOP);
    endtask

    task automatic clear_all();
        step(NOP, 0, 1'b0, 1'b1);
        chk("clr_flags", F_FLAGS, 0);
        chk("clr_cnt", F_CNT, 0);
        chk("clr_valid", F_VALID, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        sdram_resetn  = 1'b0;
        sdr_init_done = 1'b0;
        err_clr       = 1'b0;
        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = NOP;
        sdr_ba   = '0;
        sdr_addr = '0;

        nop(3);
        chk("rst_flags", F_FLAGS, 0);
        chk("rst_cnt", F_CNT, 0);
        chk("rst_valid", F_VALID, 0);
        chk("rst_bank", F_BANK, 0);
        chk("rst_open", F_OPEN, 0);

        // Still in INIT: ACT is illegal, MRS/REF are allowed.
        sdram_resetn = 1'b1;
        step(ACT, 2);
        chk("init_act_flags", F_FLAGS, 6'b100000);
        chk("init_act_bank", F_BANK, 2);
        chk("init_act_cnt", F_CNT, 1);
        chk("init_act_open", F_OPEN, 0);
        step(MRS);
        step(REF);
        chk("init_mrs_ref_cnt", F_CNT, 1);
        clear_all();
        chk("clr_bank", F_BANK, 0);
        sdr_init_done = 1'b1;
        nop(1);

        // Clean ACT/RD/PRE/ACT sequence at exact timing boundaries.
        step(ACT, 1);
        chk("seq_open_act", F_OPEN, 4'b0010);
        nop(2);
        step(RD, 1);
        nop(2);
        chk("seq_open_burst", F_OPEN, 4'b0010);
        step(PRE, 1);
        chk("seq_open_pre", F_OPEN, 0);
        nop(2);
        step(ACT, 1);
        chk("seq_flags", F_FLAGS, 0);
        chk("seq_cnt", F_CNT, 0);
        chk("seq_open_react", F_OPEN, 4'b0010);
        nop(5);
        step(PRE, 1);
        nop(2);
        chk("seq_closed", F_OPEN, 0);

        // tRCD: RD one cycle early, then on time.
        step(ACT, 2);
        nop(1);
        step(RD, 2);
        chk("trcd_flags", F_FLAGS, 6'b000010);
        chk("trcd_bank", F_BANK, 2);
        chk("trcd_cnt", F_CNT, 1);
        step(RD, 2);
        chk("trcd_ontime_cnt", F_CNT, 1);
        chk("trcd_ontime_flags", F_FLAGS, 6'b000010);
        nop(2);
        step(PRE, 2);
        nop(2);
        chk("trcd_closed", F_OPEN, 0);
        clear_all();

        // tRAS on precharge-all with two open banks.
        step(ACT, 0);
        step(ACT, 3);
        nop(2);
        chk("tras_open", F_OPEN, 4'b1001);
        step(PRE, 0, 1'b1);
        chk("tras_flags", F_FLAGS, 6'b000100);
        chk("tras_bank", F_BANK, 0);
        chk("tras_cnt", F_CNT, 1);
        chk("tras_open_after", F_OPEN, 0);
        nop(2);
        clear_all();

        // tRAS boundary: PRE at ACT+TRAS-1.
        step(ACT, 3);
        nop(4);
        step(PRE, 3);
        chk("tras_m1_flags", F_FLAGS, 6'b000100);
        chk("tras_m1_bank", F_BANK, 3);
        nop(2);
        clear_all();

        // Auto-precharge then early ACT: tRP.
        step(ACT, 0);
        nop(2);
        step(RD, 0, 1'b1);
        nop(3);
        chk("ap_open_last_beat", F_OPEN, 4'b0001);
        nop(1);
        chk("ap_open_precharging", F_OPEN, 0);
        step(ACT, 0);
        chk("trp_flags", F_FLAGS, 6'b001000);
        chk("trp_bank", F_BANK, 0);
        chk("trp_cnt", F_CNT, 1);
        chk("trp_open", F_OPEN, 4'b0001);
        nop(5);
        step(PRE, 0);
        nop(2);
        chk("trp_cnt_after", F_CNT, 1);
        clear_all();

        // REF with an open bank, then clear coincident with a new violation.
        step(ACT, 1);
        nop(2);
        step(REF);
        chk("ref_open_flags", F_FLAGS, 6'b010000);
        chk("ref_open_bank", F_BANK, 1);
        step(RD, 0, 1'b0, 1'b1);
        chk("clr_new_flags", F_FLAGS, 6'b000001);
        chk("clr_new_cnt", F_CNT, 1);
        chk("clr_new_bank", F_BANK, 0);
        chk("clr_new_valid", F_VALID, 1);
        nop(1);
        step(PRE, 1);
        nop(2);
        chk("clr_new_cnt_after", F_CNT, 1);
        clear_all();

        // Legal refresh: commands inside tRFC flagged, first legal ACT at +TRFC.
        step(REF);
        step(ACT, 3);
        chk("trfc_flags", F_FLAGS, 6'b010000);
        chk("trfc_open", F_OPEN, 0);
        nop(4);
        step(ACT, 2);
        chk("trfc_last_cnt", F_CNT, 2);
        chk("trfc_last_open", F_OPEN, 0);
        step(ACT, 2);
        chk("trfc_ok_cnt", F_CNT, 2);
        chk("trfc_ok_open", F_OPEN, 4'b0100);
        nop(5);
        step(PRE, 2);
        nop(2);
        clear_all();

        // Counter saturation: 2^CW+5 violating cycles.
        for (int k = 0; k < 14; k++) step(RD, 3);
        chk("sat_cnt14", F_CNT, 14);
        chk("sat_flags", F_FLAGS, 6'b000001);
        chk("sat_bank", F_BANK, 3);
        step(RD, 3);
        chk("sat_cnt15", F_CNT, 15);
        for (int k = 0; k < 6; k++) step(RD, 3);
        chk("sat_cnt_hold", F_CNT, 15);

        // Reset mid-burst, with a violating command present.
        step(ACT, 1);
        nop(2);
        step(RD, 1);
        chk("burst_open", F_OPEN, 4'b0010);
        sdram_resetn = 1'b0;
        step(RD, 0);
        chk("midrst_flags", F_FLAGS, 0);
        chk("midrst_cnt", F_CNT, 0);
        chk("midrst_valid", F_VALID, 0);
        chk("midrst_bank", F_BANK, 0);
        chk("midrst_open", F_OPEN, 0);
        sdram_resetn = 1'b1;
        nop(1);
        chk("post_rst_open", F_OPEN, 0);

        nop(2);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations never checked, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
